store_buffer: RTL and testbench
===============================

# store_buffer

Write-side initiator for the memory interface: queues STB/STW stores from the pipeline and performs line-granular read-modify-write transactions to memory, which accepts only full 128-bit line writes. Sits between the ALU/WB stage and the memory write port, alongside the instruction cache's read path. Provides a line-match flag so the pipeline can stall loads that hit a pending store.

## Interface

Parameters:
- ARCH_BITS, 32, address/data word width
- MEMORY_LINE_BITS, 128, memory line width (16 bytes)
- DEPTH, 4, store queue entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stReq  in  1  store request
- stByte  in  1  1 = STB (stData[7:0]), 0 = STW (stData[31:0])
- stAddr  in  32  byte address of store
- stData  in  32  store data
- stReady  out  1  queue can accept; store accepted at edge where stReq && stReady
- memReadAddr  out  32  line address {line, 4'b0}
- memReadReq  out  1  level, held until memDataValid
- memData  in  128  read line
- memDataValid  in  1  one-cycle pulse, line valid
- memWriteAddr  out  32  line address {line, 4'b0}
- memWriteData  out  128  merged line
- memWriteEnable  out  1  level, held until memWriteDone
- memWriteDone  in  1  one-cycle pulse, write complete
- ldAddr  in  32  load address to check
- ldHit  out  1  combinational: some valid entry has line == ldAddr[31:4]
- empty  out  1  no valid entries and FSM in IDLE

## Operation

- Entry: line = addr[31:4], 128-bit data, 16-bit byte mask. Little-endian: byte k at bits [8k+7:8k].
- STB: byte k = stAddr[3:0]; mask bit k set; data[8k+7:8k] = stData[7:0].
- STW: word w = stAddr[3:2]; stAddr[1:0] ignored (treated 00); mask bits 4w..4w+3 set.
- Circular FIFO, head/tail pointers wrap modulo DEPTH; count 0..DEPTH. stReady = (count != DEPTH), from registered count; push and pop in same cycle allowed, count unchanged.
- FSM states IDLE, RD, WR:
  - IDLE: count>0 and head mask == 16'hFFFF -> WR; count>0 otherwise -> RD; else stay.
  - RD: memReadReq=1, memReadAddr = head line. On memDataValid: merged = (memData & ~maskBits) | (headData & maskBits), registered; -> WR.
  - WR: memWriteEnable=1, memWriteAddr = head line, memWriteData = merged (or head data if RD skipped). On memWriteDone: pop head, -> IDLE.
- Read and write requests never overlap. memDataValid outside RD and memWriteDone outside WR are ignored.
- ldHit includes the head entry until the cycle after it is popped.

## Timing

- Reset: FIFO empty, pointers/count 0, state IDLE; stReady=1, memReadReq=0, memWriteEnable=0, ldHit=0, empty=1; address/data outputs 0. Reset mid-transaction abandons it; request lines drop the cycle after the reset edge.
- Store accepted at edge t0 -> RD (memReadReq=1) from edge t0+1.
- memDataValid sampled at edge t1 -> memWriteEnable=1 from t1+1; memReadReq=0 from t1+1.
- memWriteDone sampled at edge t2 -> entry popped, IDLE, stReady/count updated from t2+1.
- Each drained entry spends one cycle in IDLE; the next request starts at t2+2.
- Full queue: stReq ignored, stReady=0, no state change.

## Configuration

- STORE_BUFFER_COALESCE_EN defined: a store whose line equals the tail entry's line merges into the tail (bytes overwritten, mask ORed) instead of pushing, provided count>0 and (tail != head or state == IDLE). Coalescing obeys stReady (no merge while full). A merge producing a full mask lets the entry skip RD.
- Undefined: every accepted store occupies a new entry; a full mask arises only... never, so RD is always taken.

## Test plan

- Reset then STW addr 0x1004 data 0xDEADBEEF; memory returns line 0 after 3 cycles -> memWriteAddr 0x1000, memWriteData word1 = 0xDEADBEEF, other words 0; memReadReq high 3 cycles, empty=1 after memWriteDone.
- STB addr 0x200F data 0xAB, memory line all 0x11 -> written line = 0xAB111111...11 (byte 15 = 0xAB, rest 0x11).
- Hold memWriteDone low, push 4 stores -> stReady=0 after 4th; 5th stReq ignored; one memWriteDone -> stReady=1 next cycle, drain order matches push order.
- ldAddr 0x100C with pending store to 0x1000 -> ldHit=1; ldAddr 0x1010 -> ldHit=0; ldHit drops cycle after pop.
- Assert rst during RD -> next cycle memReadReq=0, empty=1, stReady=1; late memDataValid ignored.
- With STORE_BUFFER_COALESCE_EN: four STW to 0x3000/4/8/C while head busy on another line -> one entry, mask 0xFFFF, no memReadReq for it, single write of all four words.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: queues STB/STW stores and drains each entry to memory as a
// full-line read-modify-write (or a plain write when every byte is covered).
// Optional feature: define STORE_BUFFER_COALESCE_EN to merge same-line stores
// into the tail entry instead of allocating a new one.
module store_buffer #(
    parameter int ARCH_BITS        = 32,
    parameter int MEMORY_LINE_BITS = 128,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stReq,
    input  logic                        stByte,
    input  logic [ARCH_BITS-1:0]        stAddr,
    input  logic [ARCH_BITS-1:0]        stData,
    output logic                        stReady,
    output logic [ARCH_BITS-1:0]        memReadAddr,
    output logic                        memReadReq,
    input  logic [MEMORY_LINE_BITS-1:0] memData,
    input  logic                        memDataValid,
    output logic [ARCH_BITS-1:0]        memWriteAddr,
    output logic [MEMORY_LINE_BITS-1:0] memWriteData,
    output logic                        memWriteEnable,
    input  logic                        memWriteDone,
    input  logic [ARCH_BITS-1:0]        ldAddr,
    output logic                        ldHit,
    output logic                        empty
);
    localparam int LINE_BYTES = MEMORY_LINE_BITS / 8;
    localparam int OFF_BITS   = $clog2(LINE_BYTES);
    localparam int LINE_W     = ARCH_BITS - OFF_BITS;
    localparam int WORD_BYTES = ARCH_BITS / 8;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
    localparam int WORDS      = MEMORY_LINE_BITS / ARCH_BITS;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

    // Entry storage (no reset needed: validity comes from head/count)
    logic [LINE_W-1:0]           line_q [DEPTH];
    logic [MEMORY_LINE_BITS-1:0] data_q [DEPTH];
    logic [LINE_BYTES-1:0]       mask_q [DEPTH];

    logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    state_t                      state_q, state_d;
    logic [MEMORY_LINE_BITS-1:0] merged_q;

    logic [LINE_W-1:0]           st_line, ld_line;
    logic [LINE_BYTES-1:0]       st_mask, head_mask, head_mask_eff;
    logic [MEMORY_LINE_BITS-1:0] st_data, st_bits, head_bits, head_data_eff;
    logic [DEPTH-1:0]            hit_vec;
    logic                        accept, push, pop, coalesce;
    logic                        unused_ld_offset;

    assign st_line   = stAddr[ARCH_BITS-1:OFF_BITS];
    assign ld_line   = ldAddr[ARCH_BITS-1:OFF_BITS];
    assign head_mask = mask_q[head_q];
    assign unused_ld_offset = ^ldAddr[OFF_BITS-1:0];

    // Store data is replicated across the line; the byte mask selects what counts
    assign st_data = stByte ? {LINE_BYTES{stData[7:0]}} : {WORDS{stData}};

    // Byte mask of the incoming store (STW ignores the low address bits)
    always_comb begin
        st_mask = '0;
        if (stByte) begin
            st_mask[stAddr[OFF_BITS-1:0]] = 1'b1;
        end else begin
            st_mask = {{(LINE_BYTES-WORD_BYTES){1'b0}}, {WORD_BYTES{1'b1}}}
                      << (WORD_BYTES * int'(stAddr[OFF_BITS-1:WORD_SHIFT]));
        end
    end

    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_bits
        assign st_bits[8*gi +: 8]   = {8{st_mask[gi]}};
        assign head_bits[8*gi +: 8] = {8{head_mask[gi]}};
    end

    assign stReady = (count_q != CNT_W'(DEPTH));
    assign accept  = stReq && stReady;
    assign pop     = (state_q == S_WR) && memWriteDone;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PTR_W-1:0]            tail_last;
    logic [MEMORY_LINE_BITS-1:0] merge_data;
    logic [LINE_BYTES-1:0]       merge_mask;

    assign tail_last  = tail_q - PTR_W'(1);
    // The head entry is frozen once a transaction for it is under way
    assign coalesce   = accept && (count_q != '0) && (line_q[tail_last] == st_line)
                        && ((tail_last != head_q) || (state_q == S_IDLE));
    assign merge_data = (data_q[tail_last] & ~st_bits) | (st_data & st_bits);
    assign merge_mask = mask_q[tail_last] | st_mask;
    // Head view including a merge landing on the same edge
    assign head_data_eff = (coalesce && (tail_last == head_q)) ? merge_data : data_q[head_q];
    assign head_mask_eff = (coalesce && (tail_last == head_q)) ? merge_mask : head_mask;
`else
    assign coalesce      = 1'b0;
    assign head_data_eff = data_q[head_q];
    assign head_mask_eff = head_mask;
`endif

    assign push = accept && !coalesce;

    // Entry array writes: allocate at tail, or merge into the last entry
    always_ff @(posedge clk) begin
        if (push) begin
            line_q[tail_q] <= st_line;
            data_q[tail_q] <= st_data;
            mask_q[tail_q] <= st_mask;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        else if (coalesce) begin
            data_q[tail_last] <= merge_data;
            mask_q[tail_last] <= merge_mask;
        end
`endif
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: fully covered head lines skip the memory read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (count_q != '0) state_d = (&head_mask_eff) ? S_WR : S_RD;
            S_RD:   if (memDataValid)  state_d = S_WR;
            S_WR:   if (memWriteDone)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Line to be written: merged with memory after a read, or taken whole
    always_ff @(posedge clk) begin
        if (rst) begin
            merged_q <= '0;
        end else if ((state_q == S_RD) && memDataValid) begin
            merged_q <= (memData & ~head_bits) | (data_q[head_q] & head_bits);
        end else if ((state_q == S_IDLE) && (state_d == S_WR)) begin
            merged_q <= head_data_eff;
        end
    end

    // FSM outputs: request levels and zeroed address/data when inactive
    always_comb begin
        memReadReq     = (state_q == S_RD);
        memWriteEnable = (state_q == S_WR);
        memReadAddr    = memReadReq     ? {line_q[head_q], {OFF_BITS{1'b0}}} : '0;
        memWriteAddr   = memWriteEnable ? {line_q[head_q], {OFF_BITS{1'b0}}} : '0;
        memWriteData   = memWriteEnable ? merged_q : '0;
        empty          = (count_q == '0) && (state_q == S_IDLE);
    end

    // Load-hazard detection over the currently valid entries
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PTR_W-1:0] rel;
        assign rel         = PTR_W'(gi) - head_q;
        assign hit_vec[gi] = ({1'b0, rel} < count_q) && (line_q[gi] == ld_line);
    end
    assign ldHit = |hit_vec;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized stores against a queue/byte-level
// reference model of the store buffer; the bench also plays the memory.
module tb_store_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stReq = 1'b0, stByte = 1'b0;
    logic [31:0]  stAddr = '0, stData = '0;
    logic         stReady;
    logic [31:0]  memReadAddr;
    logic         memReadReq;
    logic [127:0] memData = '0;
    logic         memDataValid = 1'b0;
    logic [31:0]  memWriteAddr;
    logic [127:0] memWriteData;
    logic         memWriteEnable;
    logic         memWriteDone = 1'b0;
    logic [31:0]  ldAddr = '0;
    logic         ldHit, empty;

    store_buffer dut (
        .clk(clk), .rst(rst), .stReq(stReq), .stByte(stByte), .stAddr(stAddr),
        .stData(stData), .stReady(stReady), .memReadAddr(memReadAddr),
        .memReadReq(memReadReq), .memData(memData), .memDataValid(memDataValid),
        .memWriteAddr(memWriteAddr), .memWriteData(memWriteData),
        .memWriteEnable(memWriteEnable), .memWriteDone(memWriteDone),
        .ldAddr(ldAddr), .ldHit(ldHit), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: pending entries as line / byte data / byte mask
    logic [27:0]  q_line [$];
    logic [127:0] q_data [$];
    logic [15:0]  q_mask [$];
    logic [127:0] mem_img [logic [27:0]];
    logic [127:0] last_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_has(input logic [27:0] ln);
        foreach (q_line[i]) if (q_line[i] == ln) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic b);
        logic [127:0] data;
        logic [15:0]  m;
        int k;
        data = '0;
        m = '0;
        if (b) begin
            k = int'(a[3:0]);
            data[8*k +: 8] = d[7:0];
            m[k] = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                k = 4 * int'(a[3:2]) + i;
                data[8*k +: 8] = d[8*i +: 8];
                m[k] = 1'b1;
            end
        end
        q_line.push_back(a[31:4]);
        q_data.push_back(data);
        q_mask.push_back(m);
    endtask

    task automatic get_mem(input logic [27:0] ln, output logic [127:0] v);
        if (!mem_img.exists(ln)) mem_img[ln] = {$urandom, $urandom, $urandom, $urandom};
        v = mem_img[ln];
    endtask

    task automatic do_push(input logic [31:0] a, input logic [31:0] d, input logic b);
        stReq = 1'b1; stAddr = a; stData = d; stByte = b;
        tick();
        stReq = 1'b0;
    endtask

    // Serve the oldest model entry as memory; rd_wait<0 picks a random delay
    task automatic drain_one(input bit full_hold, input int rd_wait);
        logic [27:0]  ln;
        logic [127:0] d, mline, expw;
        logic [15:0]  m;
        int n;
        ln = q_line.pop_front();
        d  = q_data.pop_front();
        m  = q_mask.pop_front();
        get_mem(ln, mline);
        for (int k = 0; k < 16; k++) expw[8*k +: 8] = m[k] ? d[8*k +: 8] : mline[8*k +: 8];
        n = 0;
        while (memReadReq !== 1'b1 && n < 40) begin tick(); n++; end
        chk("rd_req_seen", memReadReq, 1);
        chk("rd_no_overlap", memWriteEnable, 0);
        chk("rd_addr", memReadAddr, {ln, 4'h0});
        memWriteDone = 1'b1;
        tick();
        memWriteDone = 1'b0;
        chk("stray_done_ignored", memReadReq, 1);
        n = (rd_wait < 0) ? int'($urandom_range(0, 3)) : rd_wait;
        repeat (n) begin tick(); chk("rd_hold", memReadReq, 1); end
        memData = mline; memDataValid = 1'b1;
        tick();
        memDataValid = 1'b0; memData = {$urandom, $urandom, $urandom, $urandom};
        chk("wr_en_after_valid", memWriteEnable, 1);
        chk("rd_drop_after_valid", memReadReq, 0);
        chk("wr_addr", memWriteAddr, {ln, 4'h0});
        chk("wr_data", memWriteData, expw);
        last_wdata = memWriteData;
        n = full_hold ? 2 : int'($urandom_range(0, 3));
        repeat (n) begin
            tick();
            chk("wr_hold", memWriteEnable, 1);
            if (full_hold) chk("full_hold_ready", stReady, 0);
        end
        ldAddr = {ln, 4'($urandom_range(0, 15))};
        #1;
        chk("ldhit_before_pop", ldHit, 1);
        memWriteDone = 1'b1;
        tick();
        memWriteDone = 1'b0;
        chk("wr_drop_after_done", memWriteEnable, 0);
        chk("ldhit_after_pop", ldHit, model_has(ln));
        if (full_hold) chk("ready_after_pop", stReady, 1);
        mem_img[ln] = expw;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] ln, prev;
        logic [31:0] a, d;
        logic        b;
        int          n;
        bit          saw_rd;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_stReady", stReady, 1);
        chk("rst_memReadReq", memReadReq, 0);
        chk("rst_memWriteEnable", memWriteEnable, 0);
        chk("rst_ldHit", ldHit, 0);
        chk("rst_empty", empty, 1);
        chk("rst_memReadAddr", memReadAddr, 0);
        chk("rst_memWriteAddr", memWriteAddr, 0);
        chk("rst_memWriteData", memWriteData, 0);

        // STW to 0x1004 against a zero line, read returned after 3 cycles
        mem_img[28'h100] = '0;
        do_push(32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
        model_push(32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
        chk("rd_not_yet", memReadReq, 0);
        chk("not_empty", empty, 0);
        ldAddr = 32'h0000_100C; #1;
        chk("ldhit_same_line", ldHit, 1);
        ldAddr = 32'h0000_1010; #1;
        chk("ldhit_next_line", ldHit, 0);
        tick();
        chk("rd_start", memReadReq, 1);
        drain_one(1'b0, 1);
        chk("t1_wdata", last_wdata, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000);
        chk("t1_empty", empty, 1);

        // STB to the top byte of a line of 0x11
        mem_img[28'h200] = {16{8'h11}};
        do_push(32'h0000_200F, 32'h0000_00AB, 1'b1);
        model_push(32'h0000_200F, 32'h0000_00AB, 1'b1);
        drain_one(1'b0, -1);
        chk("t2_wdata", last_wdata, {8'hAB, {15{8'h11}}});
        chk("t2_empty", empty, 1);

        // Fill the queue, try a fifth store, drain in order
        for (int j = 0; j < 4; j++) begin
            a = 32'h0000_4000 + 32'(16 * j);
            d = $urandom;
            chk("fill_ready", stReady, 1);
            do_push(a, d, 1'b0);
            model_push(a, d, 1'b0);
        end
        chk("full_ready", stReady, 0);
        do_push(32'h0000_5000, 32'h1234_5678, 1'b0);
        chk("full_ignored", stReady, 0);
        drain_one(1'b1, -1);
        while (q_line.size() > 0) drain_one(1'b0, -1);
        tick();
        chk("fill_empty", empty, 1);

        // Reset in the middle of a read
        do_push(32'h0000_6000, 32'hCAFE_F00D, 1'b0);
        tick();
        chk("pre_rst_rd", memReadReq, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_memReadReq", memReadReq, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_stReady", stReady, 1);
        memData = '1; memDataValid = 1'b1;
        tick();
        memDataValid = 1'b0;
        chk("late_valid_we", memWriteEnable, 0);
        chk("late_valid_rd", memReadReq, 0);
        chk("late_valid_empty", empty, 1);

        // Randomized rounds; consecutive stores use distinct lines
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 4);
            prev = '1;
            for (int j = 0; j < n; j++) begin
                do ln = 28'h100 + 28'($urandom_range(0, 7)); while (ln == prev);
                prev = ln;
                a = {ln, 4'($urandom_range(0, 15))};
                d = $urandom;
                b = 1'($urandom_range(0, 1));
                chk("rand_ready", stReady, 1);
                do_push(a, d, b);
                model_push(a, d, b);
            end
            chk("rand_ready_after", stReady, (n != 4));
            for (int j = 0; j < 3; j++) begin
                ln = 28'h100 + 28'($urandom_range(0, 7));
                ldAddr = {ln, 4'h3}; #1;
                chk("rand_ldhit", ldHit, model_has(ln));
            end
            while (q_line.size() > 0) drain_one(1'b0, -1);
            tick();
            chk("rand_empty", empty, 1);
        end

`ifdef STORE_BUFFER_COALESCE_EN
        // Four words of one line merge behind a busy head and skip the read
        do_push(32'h0000_7000, 32'h0BAD_0BAD, 1'b0);
        model_push(32'h0000_7000, 32'h0BAD_0BAD, 1'b0);
        tick();
        chk("co_head_busy", memReadReq, 1);
        do_push(32'h0000_3000, 32'hA0A0_A0A0, 1'b0);
        do_push(32'h0000_3004, 32'hB1B1_B1B1, 1'b0);
        do_push(32'h0000_3008, 32'hC2C2_C2C2, 1'b0);
        do_push(32'h0000_300C, 32'hD3D3_D3D3, 1'b0);
        chk("co_ready", stReady, 1);
        drain_one(1'b0, -1);
        saw_rd = 1'b0;
        n = 0;
        while (memWriteEnable !== 1'b1 && n < 10) begin
            if (memReadReq === 1'b1) saw_rd = 1'b1;
            tick();
            n++;
        end
        chk("co_no_read", saw_rd, 0);
        chk("co_we", memWriteEnable, 1);
        chk("co_addr", memWriteAddr, 32'h0000_3000);
        chk("co_data", memWriteData, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
        memWriteDone = 1'b1;
        tick();
        memWriteDone = 1'b0;
        tick();
        chk("co_empty", empty, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
